// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mem_arbiter block.
package mem_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between instruction and data requesters.
// MEM_ARB_RR_EN selects round-robin on conflict; otherwise data always wins.
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   accept_i,
`endif
  input  logic   i_valid_i,
  input  logic   d_valid_i,
  output owner_e grant_o
);

`ifdef MEM_ARB_RR_EN
  owner_e last_q;

  // Reset value OWN_I makes data the winner of the first conflict.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= OWN_I;
    end else if (accept_i) begin
      last_q <= grant_o;
    end
  end

  always_comb begin
    grant_o = OWN_I;
    if (d_valid_i && (!i_valid_i || last_q == OWN_I)) begin
      grant_o = OWN_D;
    end
  end
`else
  always_comb begin
    grant_o = d_valid_i ? OWN_D : OWN_I;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single fixed-latency memory port, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data-first priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_write,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [CNT_W-1:0] LatInit = CNT_W'(MEM_LATENCY - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  owner_e            owner_q;
  logic [DATA_W-1:0] resp_q;

  owner_e grant;
  logic   idle;
  logic   i_hs;
  logic   d_hs;

  mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
    .clk_i    (clk),
    .rst_i    (reset),
    .accept_i (i_hs | d_hs),
`endif
    .i_valid_i(i_req_valid),
    .d_valid_i(d_req_valid),
    .grant_o  (grant)
  );

  // Readiness is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    idle        = (state_q == IDLE) && !reset;
    i_req_ready = idle && i_req_valid && (grant == OWN_I);
    d_req_ready = idle && d_req_valid && (grant == OWN_D);
    i_hs        = i_req_valid && i_req_ready;
    d_hs        = d_req_valid && d_req_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      owner_q <= OWN_I;
      resp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_hs) begin
            state_q <= ACCESS;
            cnt_q   <= LatInit;
            addr_q  <= d_req_addr;
            wdata_q <= d_req_write ? d_req_wdata : '0;
            write_q <= d_req_write;
            owner_q <= OWN_D;
          end else if (i_hs) begin
            state_q <= ACCESS;
            cnt_q   <= LatInit;
            addr_q  <= i_req_addr;
            wdata_q <= '0;
            write_q <= 1'b0;
            owner_q <= OWN_I;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            resp_q  <= write_q ? '0 : mem_dout;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr     = '0;
    mem_din      = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    if (state_q == ACCESS) begin
      mem_addr  = addr_q;
      mem_din   = wdata_q;
      mem_read  = !write_q;
      mem_write = write_q && (cnt_q == '0);
    end
    i_resp_valid = (state_q == RESP) && (owner_q == OWN_I);
    d_resp_valid = (state_q == RESP) && (owner_q == OWN_D);
    i_resp_data  = resp_q;
    d_resp_data  = resp_q;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 4, cycles the memory address is held per access (legal range 1..15; 0 illegal).
REQ-002 Parameter ADDR_W, default 32, address width; DATA_W, default 32, data width.
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 i_req_valid in 1 / i_req_ready out 1 / i_req_addr in ADDR_W: instruction-fetch request, read-only.
REQ-006 i_resp_valid out 1 / i_resp_data out DATA_W: instruction response.
REQ-007 d_req_valid in 1 / d_req_ready out 1 / d_req_addr in ADDR_W / d_req_write in 1 / d_req_wdata in DATA_W: data request (write=1 store, 0 load).
REQ-008 d_resp_valid out 1 / d_resp_data out DATA_W: data response; store ack carries 0.
REQ-009 mem_addr out ADDR_W / mem_din out DATA_W / mem_read out 1 / mem_write out 1 / mem_dout in DATA_W: shared memory port; memory reads combinationally, writes on posedge when mem_write=1.

Function
REQ-010 FSM states IDLE, ACCESS, RESP; only one transaction in flight.
REQ-011 IDLE: grant computed combinationally from valids; x_req_ready=1 only for the granted requester, and only in IDLE.
REQ-012 Handshake = valid && ready on a posedge; block latches addr, wdata, write, owner; IDLE->ACCESS; counter loaded MEM_LATENCY-1.
REQ-013 Valid deasserted before handshake has no effect; requests are not queued.
REQ-014 ACCESS: mem_addr=latched addr, mem_read=!write, mem_din=latched wdata; counter decrements each cycle.
REQ-015 mem_write=1 for exactly one cycle, the ACCESS cycle with counter==0, stores only.
REQ-016 At counter==0: loads capture mem_dout into response register; ACCESS->RESP.
REQ-017 RESP: owner's resp_valid=1 exactly one cycle with held data, other resp_valid=0; RESP->IDLE; no response backpressure.
REQ-018 Latency: handshake at edge T -> resp_valid high during cycle T+MEM_LATENCY+1; back-to-back throughput one transaction per MEM_LATENCY+2 cycles.
REQ-019 Outside ACCESS: mem_addr=0, mem_din=0, mem_read=0, mem_write=0.
REQ-020 resp_data holds last value between responses; only resp_valid qualifies it.
REQ-021 Simultaneous i/d valid in IDLE resolved per REQ-026/027; loser's ready stays 0.

Reset
REQ-022 reset asserted: state=IDLE, counter=0, all outputs 0, response register 0, in-flight transaction dropped.
REQ-023 Reset mid-ACCESS shall produce no mem_write and no response, even if counter==0 that cycle.
REQ-024 First handshake possible on the first posedge after reset deasserts.

Configuration
REQ-025 Macro MEM_ARB_RR_EN selects arbitration policy.
REQ-026 Without MEM_ARB_RR_EN: fixed priority, data over instruction whenever both valid.
REQ-027 With MEM_ARB_RR_EN: last-owner register; on conflict grant the requester not granted last; reset value = instruction, so data wins first conflict; single requester always granted.

Structure
REQ-028 Package mem_arb_pkg holds state enum (IDLE, ACCESS, RESP), owner enum (OWN_I, OWN_D), and counter width constant.
REQ-029 Sub-module mem_arb_grant: combinational grant logic plus last-owner register under MEM_ARB_RR_EN.

Verification (MEM_LATENCY=4)
REQ-030 Store d addr 0x10 data 0xDEADBEEF at T -> mem_write=1 only at T+4, d_resp_valid at T+5 with data 0.
REQ-031 Load d addr 0x10 after REQ-030 -> mem_read=1 for 4 cycles, d_resp_data=0xDEADBEEF at handshake+5.
REQ-032 i and d valid same cycle in IDLE -> default build: d granted, i granted after d_resp; RR build: alternate d,i,d,i over 4 conflicts.
REQ-033 reset at third ACCESS cycle of a store to 0x20 -> no mem_write, no resp, memory 0x20 unchanged, i_req_ready=1 next cycle if i valid.
REQ-034 Continuous i requests, addrs 0x0,0x4,0x8 -> i_resp_valid every 6 cycles, single-cycle pulses, correct data.
